// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: default sizes,
// FSM state encoding and width helpers used by the top and the picker.
package fifo_wr_arbiter_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  // Arbiter FSM: waiting to pick a requester, or streaming a granted burst.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first asserted valid bit at or after ptr_i,
// wrapping past the top index back to 0.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [GW-1:0]   ptr_i,
  output logic [GW-1:0]   idx_o,
  output logic            any_o
);

  logic [GW-1:0] cand;

  // Walk the requesters starting at the pointer and keep the first hit.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = GW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && valid_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO among NREQ producers.
// Grants one requester at a time for up to BURST beats, registers the
// write strobe/data toward the FIFO, and tracks occupancy itself so that
// no write is ever issued into a full buffer.
//
// Handshake: requester i's byte is transferred at a rising edge where
// req_valid[i] && req_ready[i]. req_ready is one-hot or zero, depends
// combinationally on req_valid of the granted index, and a requester must
// hold its byte stable while valid is high and ready is low.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     fifo_write_en,
  output logic [DW-1:0]            fifo_data_in,
  input  logic                     fifo_full,
  input  logic                     fifo_pop,
  output logic [cnt_w(DEPTH)-1:0]  level,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     err,
  output state_t                   dbg_state
);

  localparam int GW = idx_w(NREQ);
  localparam int LW = cnt_w(DEPTH);
  localparam int BW = cnt_w(BURST);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [BW-1:0] BURST_L = BW'(BURST);
  localparam logic [GW-1:0] LAST_L  = GW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [LW-1:0]   level_q, level_d;
  logic            err_q, err_d;
  logic            wr_en_q;
  logic [DW-1:0]   wr_data_q, wr_data_d;

  logic [DW-1:0]   data_arr [NREQ];
  logic [DW-1:0]   grant_data;
  logic            grant_valid;
  logic            credit_ok;
  logic            can_take;
  logic            accept;
  logic            pop_ok;
  logic            err_set;
  logic [GW-1:0]   pick_idx;
  logic            pick_any;

  // Unpack the flat requester data bus into one byte per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DW +: DW];
  end

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign grant_valid = req_valid[grant_q];
  assign grant_data  = data_arr[grant_q];
  assign credit_ok   = (level_q < DEPTH_L);

  // Only the granted requester may see ready, and only while there is
  // credit, no error, and the block is out of reset.
  always_comb begin
    can_take  = (state_q == ST_BURST) && credit_ok && !err_q && rst;
    req_ready = '0;
    if (can_take) begin
      req_ready[grant_q] = grant_valid;
    end
    accept = can_take && grant_valid;
  end

  // Occupancy and sticky error: a pop at zero is flagged and ignored,
  // and a full flag while credit remains means the count disagrees with the FIFO.
  always_comb begin
    pop_ok  = fifo_pop && (level_q != '0);
    level_d = level_q;
    if (accept && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (!accept && pop_ok) begin
      level_d = level_q - LW'(1);
    end
    err_set = (fifo_full && credit_ok) || (fifo_pop && (level_q == '0));
    err_d   = err_q || err_set;
  end

  // Arbitration FSM: pick in IDLE, stream the granted requester in BURST,
  // and hand the pointer to the next index whenever a burst ends.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && credit_ok && !err_q) begin
          state_d = ST_BURST;
          grant_d = pick_idx;
          beat_d  = '0;
        end
      end
      ST_BURST: begin
        if (accept) begin
          beat_d    = beat_q + BW'(1);
          wr_data_d = grant_data;
        end
        if ((accept && (beat_d == BURST_L)) || !grant_valid ||
            (level_d == DEPTH_L) || err_q) begin
          state_d = ST_IDLE;
          rr_d    = (grant_q == LAST_L) ? '0 : grant_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and the registered FIFO write port; reset wins over
  // any accept presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      level_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      level_q   <= level_d;
      err_q     <= err_d;
      wr_en_q   <= accept;
      wr_data_q <= wr_data_d;
    end
  end

  assign fifo_write_en = wr_en_q;
  assign fifo_data_in  = wr_data_q;
  assign level         = level_q;
  assign grant_id      = grant_q;
  assign err           = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester byte sources, an
// expected write queue, and checks on level/err/grant at key points.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int BURST = 4;
  localparam int LW    = 5;
  localparam int GW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_write_en;
  logic [DW-1:0]     fifo_data_in;
  logic              fifo_full;
  logic              fifo_pop;
  logic [LW-1:0]     level;
  logic [GW-1:0]     grant_id;
  logic              err;
  state_t            dbg_state;

  // Clock / reset block
  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NREQ  (NREQ),
    .DW    (DW),
    .DEPTH (DEPTH),
    .BURST (BURST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_pop      (fifo_pop),
    .level         (level),
    .grant_id      (grant_id),
    .err           (err),
    .dbg_state     (dbg_state)
  );

  // Scoreboard state
  logic [DW-1:0] exp_q[$];
  int            wr_cyc[$];
  logic [DW-1:0] src_mem [NREQ][32];
  int            src_wr [NREQ];
  int            src_rd [NREQ];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_src();
    for (int i = 0; i < NREQ; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = src_mem[i][src_rd[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    drive_src();
  endtask

  task automatic load(input int r, input logic [DW-1:0] b, input bit push);
    src_mem[r][src_wr[r]] = b;
    src_wr[r]++;
    if (push) exp_q.push_back(b);
    drive_src();
  endtask

  // One clock: note handshakes before the edge, advance sources and
  // compare any FIFO write just after it.
  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready & {NREQ{rst}};
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) src_rd[i]++;
    end
    drive_src();
    if (fifo_write_en) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(fifo_write_en), 32'(0));
      end else begin
        check("wr_data", 32'(fifo_data_in), 32'(exp_q.pop_front()));
        wr_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    wr_cyc.delete();
    clear_src();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    fifo_full = 1'b0;
    fifo_pop  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    clear_src();
    tick();
    tick();

    // Reset state
    check("rst_level", 32'(level), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check("rst_wr_en", 32'(fifo_write_en), 32'(0));
    check("rst_data", 32'(fifo_data_in), 32'(0));
    check("rst_grant", 32'(grant_id), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;

    // Single requester, six bytes: burst of four, one idle cycle, then two
    wr_cyc.delete();
    for (int k = 0; k < 6; k++) load(0, 8'(8'hA1 + k), 1'b1);
    drain(40);
    check("t1_level", 32'(level), 32'(6));
    check("t1_grant", 32'(grant_id), 32'(0));
    check("t1_nwr", 32'(wr_cyc.size()), 32'(6));
    if (wr_cyc.size() == 6) begin
      check("t1_b2b", 32'(wr_cyc[3] - wr_cyc[0]), 32'(3));
      check("t1_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'(2));
      check("t1_tail", 32'(wr_cyc[5] - wr_cyc[4]), 32'(1));
    end
    fifo_pop = 1'b1;
    repeat (6) tick();
    fifo_pop = 1'b0;
    check("t1_popped", 32'(level), 32'(0));
    check("t1_err", 32'(err), 32'(0));

    // All four requesters at once: round-robin 0,1,2,3, then wrap to 0
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      load(r, 8'(8'h10 * (r + 1)), 1'b1);
      load(r, 8'(8'h10 * (r + 1) + 1), 1'b1);
    end
    drain(60);
    check("t2_grant_last", 32'(grant_id), 32'(3));
    repeat (2) tick();
    load(0, 8'h50, 1'b1);
    load(3, 8'h60, 1'b1);
    drain(20);
    repeat (2) tick();
    check("t2_level", 32'(level), 32'(10));

    // Fill to DEPTH without pops; a pending fifth byte must wait for credit
    do_reset();
    for (int r = 0; r < NREQ; r++)
      for (int k = 0; k < 4; k++) load(r, 8'(16 * r + k), 1'b1);
    load(0, 8'hEE, 1'b0);
    drain(100);
    repeat (4) tick();
    check("t3_full_level", 32'(level), 32'(16));
    check("t3_full_ready", 32'(req_ready), 32'(0));
    check("t3_full_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.push_back(8'hEE);
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("t3_pop_level", 32'(level), 32'(15));
    check("t3_pop_ready", 32'(req_ready), 32'(0));
    tick();
    check("t3_regrant_state", 32'(dbg_state), 32'(ST_BURST));
    check("t3_regrant_ready", 32'(req_ready), 32'(4'b0001));
    tick();
    check("t3_refill_level", 32'(level), 32'(16));
    drain(5);

    // Accept and pop on the same edge at DEPTH-1
    repeat (2) tick();
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("t4_level15", 32'(level), 32'(15));
    load(1, 8'h5A, 1'b1);
    load(1, 8'h5B, 1'b1);
    tick();
    check("t4_ready", 32'(req_ready), 32'(4'b0010));
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("t4_same_edge_level", 32'(level), 32'(15));
    check("t4_same_edge_wr", 32'(fifo_write_en), 32'(1));
    check("t4_same_edge_state", 32'(dbg_state), 32'(ST_BURST));
    tick();
    check("t4_final_level", 32'(level), 32'(16));
    drain(5);

    // Error: fifo_full while credit remains, and pop at zero
    do_reset();
    for (int k = 0; k < 3; k++) load(2, 8'(8'hC0 + k), 1'b1);
    drain(20);
    repeat (2) tick();
    check("t5_level3", 32'(level), 32'(3));
    fifo_full = 1'b1;
    tick();
    fifo_full = 1'b0;
    check("t5_err_full", 32'(err), 32'(1));
    load(2, 8'hC3, 1'b0);
    repeat (3) tick();
    check("t5_err_ready", 32'(req_ready), 32'(0));
    check("t5_err_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_err_level", 32'(level), 32'(3));
    do_reset();
    check("t5_err_cleared", 32'(err), 32'(0));
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("t5_err_underflow", 32'(err), 32'(1));
    check("t5_level_zero", 32'(level), 32'(0));

    // Reset mid-burst after two accepts; the byte offered in the reset cycle is lost
    do_reset();
    load(3, 8'hB0, 1'b1);
    load(3, 8'hB1, 1'b1);
    for (int k = 2; k < 5; k++) load(3, 8'(8'hB0 + k), 1'b0);
    tick();
    check("t6_granted", 32'(dbg_state), 32'(ST_BURST));
    tick();
    tick();
    check("t6_level2", 32'(level), 32'(2));
    rst = 1'b0;
    tick();
    check("t6_wr_en", 32'(fifo_write_en), 32'(0));
    check("t6_level", 32'(level), 32'(0));
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_grant", 32'(grant_id), 32'(0));
    check("t6_ready", 32'(req_ready), 32'(0));
    clear_src();
    rst = 1'b1;
    repeat (4) tick();
    check("t6_exp_empty", 32'(exp_q.size()), 32'(0));

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one 16-entry, 8-bit FIFO among several producers. It grants one requester at a time for a bounded burst and drives the FIFO write port from a registered mux. It keeps its own occupancy count, raised on accepts and lowered on downstream pops, so a write is never issued into a full buffer. It sits directly in front of the FIFO; the FIFO read side and its consumer are unchanged.

## Interface
- NREQ, 4: number of requesters (2..8)
- DW, 8: data width; must match FIFO data_in
- DEPTH, 16: FIFO entries; credit limit
- BURST, 4: maximum beats per grant (1..DEPTH)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- req_valid  in  NREQ  requester i has a byte
- req_data  in  NREQ*DW  byte of requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot or zero; byte i accepted at edge where valid[i]&&ready[i]
- fifo_write_en  out  1  registered write strobe to FIFO
- fifo_data_in  out  DW  registered write data
- fifo_full  in  1  FIFO full flag (cross-check only)
- fifo_pop  in  1  FIFO read accepted this cycle (one byte left)
- level  out  clog2(DEPTH)+1  bytes accepted and not yet popped
- grant_id  out  clog2(NREQ)  current/last granted index
- err  out  1  sticky: fifo_full high while level<DEPTH, or pop at level 0

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any req_valid and level<DEPTH and !err, pick the first valid index at or after rr_ptr (wrapping), load grant_id, beat counter=0, go BURST. req_ready all zero in IDLE.
- BURST: req_ready[grant_id] = req_valid[grant_id] && level<DEPTH && !err (combinational); all other bits 0.
- Each accept: fifo_write_en<=1, fifo_data_in<=req_data[grant_id], beat+=1, level+=1.
- BURST exit to IDLE at the edge when: beat reaches BURST on this accept; or req_valid[grant_id]==0; or level reaches DEPTH. On exit rr_ptr<=grant_id+1 mod NREQ.
- level: +1 on accept, -1 on fifo_pop, unchanged when both. Never exceeds DEPTH; never underflows (pop at 0 sets err and level stays 0).
- err set when fifo_full==1 with level<DEPTH, or on pop at level 0; cleared only by reset. While err, no grants; an active burst ends the next edge.
- Reset (rst==0) at any cycle, including mid-burst: state IDLE, rr_ptr=0, grant_id=0, beat=0, level=0, err=0, req_ready=0, fifo_write_en=0, fifo_data_in=0. An accept in the reset cycle is discarded.

## Timing
- Request to grant: valid seen in IDLE at edge N -> BURST at N+1 -> req_ready high during cycle N+1.
- Accept at edge M -> fifo_write_en/fifo_data_in high/valid during cycle M+1 (one-cycle latency); fifo_write_en is a one-cycle pulse per byte, back-to-back in a burst.
- Sustained throughput: BURST bytes per BURST+1 cycles (one IDLE cycle per re-arbitration).
- level updates at the accept edge, not the FIFO write edge; credit is therefore conservative by one cycle.
- fifo_pop and an accept on the same edge at level==DEPTH-1: level stays DEPTH-1, burst continues.

## Structure
- Shared package: DW, DEPTH defaults, FSM state encoding (IDLE=0, BURST=1), clog2 helper width constants.
- One sub-module natural: rr_pick, combinational first-set-at-or-after-pointer search over NREQ bits returning index and any_valid.
- Top holds FSM, beat counter, level counter, err, output registers.

## Test plan
- Single requester 0 sends 0xA1..0xA6, BURST=4 -> writes A1..A4 back-to-back, one idle cycle, A5,A6; level=6; grant_id=0.
- All four valid continuously, 2 bytes each, from reset -> grant order 0,1,2,3; requester 1 granted after 0's burst; rr_ptr wraps to 0 after 3.
- Fill to 16 with no pops -> 16th accept drops req_ready, level=16, no 17th fifo_write_en; one fifo_pop -> level 15, next grant one cycle later.
- Accept and fifo_pop on same edge at level 15 -> level stays 15, fifo_write_en pulses next cycle.
- fifo_full forced high at level 3 -> err=1 next cycle, req_ready 0 thereafter; fifo_pop at level 0 also sets err.
- rst low mid-burst after 2 accepts -> next cycle fifo_write_en=0, level=0, state IDLE, grant_id=0; byte in reset cycle never written.
